// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: op codes, bus/register
// widths, reset/write-enable levels and the LSU FSM state type.
package mem_lsu_pkg;

  localparam int unsigned REG_BUS_W      = 32;
  localparam int unsigned REG_ADDR_BUS_W = 5;

  localparam logic [REG_BUS_W-1:0] ZERO_WORD     = '0;
  localparam logic                 RST_ENABLE    = 1'b1;
  localparam logic                 WRITE_ENABLE  = 1'b1;
  localparam logic                 WRITE_DISABLE = 1'b0;

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_load_op(op) || is_store_op(op);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: byte enables and replicated store data for
// the bus, plus lane extraction with sign/zero extension for loads.
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_rdata,
  output logic [3:0]  sel,
  output logic [31:0] store_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane 0 (addr 0) is the most significant byte.
  always_comb begin
    byte_lane = load_rdata[31:24];
    case (addr_lo)
      2'd0: byte_lane = load_rdata[31:24];
      2'd1: byte_lane = load_rdata[23:16];
      2'd2: byte_lane = load_rdata[15:8];
      2'd3: byte_lane = load_rdata[7:0];
      default: byte_lane = load_rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? load_rdata[15:0] : load_rdata[31:16];
  end

  // Halfword ops look only at addr[1] and word ops ignore addr[1:0],
  // which is what forces misaligned addresses down to alignment.
  always_comb begin
    sel         = 4'b0000;
    store_wdata = ZERO_WORD;
    load_data   = ZERO_WORD;
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        sel         = 4'b1000 >> addr_lo;
        store_wdata = {4{store_data[7:0]}};
        load_data   = (aluop == EXE_LB_OP) ? {{24{byte_lane[7]}}, byte_lane}
                                           : {24'd0, byte_lane};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        sel         = addr_lo[1] ? 4'b0011 : 4'b1100;
        store_wdata = {2{store_data[15:0]}};
        load_data   = (aluop == EXE_LH_OP) ? {{16{half_lane[15]}}, half_lane}
                                           : {16'd0, half_lane};
      end
      EXE_LW_OP, EXE_SW_OP: begin
        sel         = 4'b1111;
        store_wdata = store_data;
        load_data   = load_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: ALU pass-through plus a single-outstanding req/ack
// load/store engine. LSU_ALIGN_CHECK_EN adds misalign_o and blocks misaligned ops.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [31:0]       hi_i,
  input  logic [31:0]       lo_i,
  input  logic              whilo_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       reg2_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  output logic              whilo_o,
  output logic              stallreq,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
`ifdef LSU_ALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);

  lsu_state_e  state, state_nxt;
  logic [31:0] rdata_q;
  logic        mem_op;
  logic        load_op;
  logic        misalign;
  logic        start;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign mem_op  = is_mem_op(aluop_i);
  assign load_op = is_load_op(aluop_i);

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (aluop_i)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misalign = mem_addr_i[0];
      EXE_LW_OP, EXE_SW_OP:             misalign = |mem_addr_i[1:0];
      default:                          misalign = 1'b0;
    endcase
  end
  assign misalign_o = (state == LSU_IDLE) && misalign;
`else
  assign misalign = 1'b0;
`endif

  mem_lane_align u_lane (
    .aluop       (aluop_i),
    .addr_lo     (mem_addr_i[1:0]),
    .store_data  (reg2_i),
    .load_rdata  (rdata_q),
    .sel         (lane_sel),
    .store_wdata (lane_wdata),
    .load_data   (lane_load)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= LSU_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= !load_op;
        bus_addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
        bus_sel   <= lane_sel;
        bus_wdata <= lane_wdata;
      end else if ((state == LSU_BUSY) && bus_ack) begin
        bus_req <= 1'b0;
        rdata_q <= bus_rdata;
      end
    end
  end

  // Result reaches mem_wb in DONE, the only state where stallreq drops.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stallreq  = 1'b0;
    wd_o      = wd_i;
    wreg_o    = wreg_i;
    wdata_o   = wdata_i;
    hi_o      = hi_i;
    lo_o      = lo_i;
    whilo_o   = whilo_i;
    case (state)
      LSU_IDLE: begin
        if (mem_op) begin
          wreg_o  = WRITE_DISABLE;
          whilo_o = WRITE_DISABLE;
          if (!misalign) begin
            stallreq  = 1'b1;
            start     = 1'b1;
            state_nxt = LSU_BUSY;
          end
        end
      end
      LSU_BUSY: begin
        stallreq = 1'b1;
        if (mem_op) begin
          wreg_o  = WRITE_DISABLE;
          whilo_o = WRITE_DISABLE;
        end
        if (bus_ack) state_nxt = LSU_DONE;
      end
      LSU_DONE: begin
        if (mem_op) begin
          wreg_o  = load_op ? wreg_i : WRITE_DISABLE;
          wdata_o = lane_load;
          whilo_o = WRITE_DISABLE;
        end
        state_nxt = LSU_IDLE;
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

endmodule
